// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // Encodings match the RV32M funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Any of DIV, DIVU, REM, REMU.
    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic is_rem(input muldiv_op_e op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    // rs1 is treated as two's complement. MUL is listed because its low
    // product bits do not depend on operand signedness.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    // rs2 is treated as two's complement (MULHSU keeps rs2 unsigned).
    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for RV32M.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready
// && !flush; the requester holds in_valid until then. The result is
// presented with a single-cycle out_valid pulse and stays on result until
// the next pulse. flush drops any operation in flight without a pulse.
//
// Datapath sharing: opnd_q holds the multiplicand (multiply) or the divisor
// (divide); shift_q holds the multiplier / dividend and collects the low
// product bits / quotient bits; acc_q is the XLEN+1 bit partial-sum /
// remainder register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] shift_q, shift_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_res_q, sign_res_d;
    logic            sign_rem_q, sign_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    // Request decode
    muldiv_op_e      in_op;
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    // Iteration and fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    // Decode the incoming request, operand magnitudes and fast-path result.
    always_comb begin
        in_op    = muldiv_op_e'(op);
        accept   = in_valid && (state_q == ST_IDLE) && !flush;
        a_neg    = is_signed_a(in_op) && rs1[XLEN-1];
        b_neg    = is_signed_b(in_op) && rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = (rs2 == '0);
        div_ovf  = (in_op inside {OP_DIV, OP_REM}) && (rs1 == MIN_VAL) && (rs2 == '1);
        fast     = is_div(in_op) && (div_zero || div_ovf);
        fast_res = '0;
        if (div_zero) begin
            fast_res = is_rem(in_op) ? rs1 : '1;
        end else if (div_ovf) begin
            fast_res = is_rem(in_op) ? '0 : MIN_VAL;
        end
    end

    // One radix-2 step of multiply and restoring divide, plus final sign fix-up.
    always_comb begin
        // Multiply: acc_q[XLEN:1] is the running high half, acc_q[0] has
        // already been shifted into shift_q.
        mul_sum  = {1'b0, acc_q[XLEN:1]} + {1'b0, (shift_q[0] ? opnd_q : '0)};
        // Divide: bring the next dividend bit in and trial-subtract.
        rem_sh   = {acc_q[XLEN-1:0], shift_q[XLEN-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
        div_ge   = !div_diff[XLEN+1];

        prod     = {acc_q[XLEN:1], shift_q};
        prod_s   = sign_res_q ? -prod : prod;
        quo_s    = sign_res_q ? -shift_q : shift_q;
        rem_s    = sign_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

        case (op_q)
            OP_MUL:                        fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo_s;
            OP_REM, OP_REMU:               fix_res = rem_s;
            default:                       fix_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: both handshake outputs are pure functions of the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values: load on accept, iterate in CALC, select in FIX.
    always_comb begin
        op_d       = op_q;
        opnd_d     = opnd_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && fast) begin
                    result_d = fast_res;
                end else if (accept) begin
                    op_d       = in_op;
                    opnd_d     = is_div(in_op) ? b_mag : a_mag;
                    shift_d    = is_div(in_op) ? a_mag : b_mag;
                    acc_d      = '0;
                    cnt_d      = CW'(XLEN - 1);
                    sign_res_d = a_neg ^ b_neg;
                    sign_rem_d = a_neg;
                end
            end
            ST_CALC: begin
                if (!flush) begin
                    if (is_div(op_q)) begin
                        acc_d   = div_ge ? div_diff[XLEN:0] : rem_sh;
                        shift_d = {shift_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d   = mul_sum;
                        shift_d = {mul_sum[0], shift_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                if (!flush) begin
                    result_d = fix_res;
                end
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_MUL;
            opnd_q     <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
        end else begin
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): vector table plus flush and
// reset sequences.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] prev_res = '0;
    int checks = 0;
    int errors = 0;
    int t_acc = 0;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a falling edge; presents the request for one cycle.
    task automatic start_op(input string tag, input logic [2:0] o,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        check({tag, " in_ready_before_accept"}, in_ready, 1);
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        t_acc    = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for the out_valid pulse, checks latency, busy behaviour, result
    // and the pulse width. Returns just after the falling edge following the pulse.
    task automatic wait_out(input string tag, input int exp_lat);
        int lat = -1;
        int ready_bad = 0;
        int held_bad = 0;
        logic [XLEN-1:0] exp;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - t_acc;
                break;
            end
            if (in_ready) ready_bad++;
            if (result !== prev_res) held_bad++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " in_ready_low_while_busy"}, ready_bad, 0);
        check({tag, " result_held_while_busy"}, held_bad, 0);
        exp = exp_q.pop_front();
        check({tag, " result"}, result, exp);
        prev_res = exp;
        @(negedge clk);
        check({tag, " out_valid_single_cycle"}, out_valid, 0);
        check({tag, " in_ready_after_done"}, in_ready, 1);
        check({tag, " result_held_after"}, result, exp);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // op, a, b, expected, latency
        vecs.push_back('{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 34});
        vecs.push_back('{3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 34});
        vecs.push_back('{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{3'd6, 32'h00000005, 32'h00000000, 32'h00000005, 1});
        vecs.push_back('{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34});
        vecs.push_back('{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 34});
        vecs.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{3'd4, 32'h80000000, 32'h00000001, 32'h80000000, 34});
        vecs.push_back('{3'd3, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{3'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, issued back to back
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            exp_q.push_back(vecs[i].res);
            start_op(tag, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_out(tag, vecs[i].lat);
        end

        // flush and in_valid together in IDLE: nothing accepted
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 3'd4;
        rs1      = 32'd5;
        rs2      = 32'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_flush out_valid", out_valid, 0);
        check("idle_flush in_ready", in_ready, 1);
        check("idle_flush result", result, prev_res);

        // flush at T+10 of a DIV, then MUL 3 x 4 accepted at T+11
        start_op("flush_div", 3'd4, 32'd100, 32'd7);
        for (int i = 0; i < 20 && cyc != t_acc + 10; i++) @(negedge clk);
        check("flush_div busy_before_flush", in_ready, 0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_div in_ready_after", in_ready, 1);
        check("flush_div no_out_valid", out_valid, 0);
        check("flush_div result_unchanged", result, prev_res);
        exp_q.push_back(32'd12);
        start_op("mul_after_flush", 3'd0, 32'd3, 32'd4);
        wait_out("mul_after_flush", 34);

        // Reset pulse at T+5 of a DIVU
        start_op("reset_mid", 3'd5, 32'd10, 32'd3);
        for (int i = 0; i < 20 && cyc != t_acc + 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid out_valid", out_valid, 0);
        check("reset_mid in_ready", in_ready, 1);
        check("reset_mid result", result, 0);
        prev_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back DIVU / REMU after reset
        exp_q.push_back(32'd3);
        start_op("divu_10_3", 3'd5, 32'd10, 32'd3);
        wait_out("divu_10_3", 34);
        exp_q.push_back(32'd1);
        start_op("remu_10_3", 3'd7, 32'd10, 32'd3);
        wait_out("remu_10_3", 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RV32M multiply/divide unit that replaces the single-cycle `*`, `/`, `%` paths of the execute-stage ALU. It accepts one operation via a valid/ready handshake and computes it with a radix-2 shift-add or restoring-divide loop over `XLEN` cycles. It returns the result with a one-cycle `out_valid` pulse; the core stalls on `in_ready`/`out_valid`. Divide-by-zero and signed overflow are resolved on a one-cycle fast path with RISC-V-mandated results.

## Interface
- `XLEN`, default 32: operand and result width; any even value ≥ 8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit idle and able to accept a request.
- `op` input 3: RV32M funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` input XLEN: operand a (dividend / multiplicand).
- `rs2` input XLEN: operand b (divisor / multiplier).
- `flush` input 1: abort any operation in flight (pipeline redirect).
- `out_valid` output 1: one-cycle pulse; `result` is valid.
- `result` output XLEN: result; held stable from the `out_valid` pulse until the next `out_valid`.

## Operation
- Accept when `in_valid && in_ready && !flush`. On accept, latch `op`, `rs1` and `rs2`.
- Signed operands: take magnitudes, iterate unsigned, then sign-correct.
  - MULHSU: only `rs1` is signed.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Multiply: 2·XLEN-bit product.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, MSB first. Remainder register is XLEN+1 bits.
- Fast path, decided at accept:
  - `rs2 == 0`: DIV/DIVU return all ones; REM/REMU return `rs1`.
  - DIV with `rs1 == MIN` and `rs2 == -1`: returns MIN. REM with the same operands returns 0.
- States:
  - IDLE: `in_ready`=1. Accept → CALC, or → DONE on the fast path.
  - CALC: count down from XLEN-1. Counter 0 → FIX.
  - FIX: sign correction and result select → DONE.
  - DONE: `out_valid`=1, `result` registered → IDLE.
- `flush` in any state returns to IDLE on the next edge with no `out_valid`. `flush` and `in_valid` in the same IDLE cycle: flush wins and nothing is accepted.
- `in_valid` while not in IDLE is ignored; the requester must hold it.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `result`=0.
  - Internal registers 0.
- Accept edge at cycle T:
  - Normal path: CALC for T+1…T+XLEN, FIX at T+XLEN+1, `out_valid` at T+XLEN+2. For XLEN=32 that is T+34.
  - Fast path: `out_valid` at T+1.
- `in_ready`:
  - Low from T+1 until the cycle after `out_valid`.
  - Next accept possible at T+XLEN+3 (normal) or T+2 (fast path).
- `rst_n` low mid-operation: immediate return to reset values, no `out_valid`.
- `flush` at cycle F while busy: `in_ready`=1 at F+1, and `result` keeps its previous value.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_e`, 3-bit enum with the funct3 encodings above.
  - `muldiv_state_e`: IDLE, CALC, FIX, DONE.
  - Helper predicates `is_div(op)`, `is_signed_a(op)`, `is_signed_b(op)`.
- Single module `muldiv_unit`. The datapath is small enough that no sub-module is warranted. The counter width is `$clog2(XLEN)`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB. `out_valid` exactly at T+34 for one cycle; `in_ready` low T+1…T+34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division signs:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
  - REMU 100 % 7 → 2.
- Fast path, each with `out_valid` at T+1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- `flush` at T+10 of a DIV → no `out_valid`, `in_ready`=1 at T+11, `result` unchanged. New MUL 3 × 4 accepted at T+11 → 12 at T+45.
- `rst_n` pulsed low at T+5 → `out_valid`=0 and `in_ready`=1 immediately. Then back-to-back DIVU 10/3 and REMU 10/3 → 3, then 1, with `result` held between pulses.
